// File: rtl/trng_bit_collector_pkg.sv
// Purpose: shared TRNG word-size parameters and collector types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trng_bit_collector_pkg;

    // Entropy word width shared by the collector and the holding logic.
    localparam int TRNG_WORD_W     = 32;
    localparam int TRNG_WORD_CNT_W = $clog2(TRNG_WORD_W + 1);

    // Which half of a von Neumann pair the next strobe supplies.
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } pair_phase_t;

endpackage

// File: rtl/trng_vn_debias.sv
// Purpose: von Neumann debiaser (or raw pass-through) on strobed noise bits.
// Latency: combinational accept in the strobe cycle; pair state is registered.
// Backpressure: none; every strobe is consumed, clear discards a coincident strobe.
module trng_vn_debias
    import trng_bit_collector_pkg::*;
(
    input  logic rng_clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic rng_bit,
    input  logic bypass_vn,
    input  logic clear,
    output logic accept,
    output logic accept_bit
);

    pair_phase_t pair_phase;
    logic        pair_bit;

    // A bit is accepted on every raw strobe, or on the second half of an unequal pair.
    assign accept = strobe & ~clear &
                    (bypass_vn | ((pair_phase == PH_SECOND) & (pair_bit != rng_bit)));

    // Pair 10 yields 1 and 01 yields 0, so the stored first bit is the output.
    assign accept_bit = bypass_vn ? rng_bit : pair_bit;

    // Track pair position; held at the first phase in bypass and after any clear.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_phase <= PH_FIRST;
            pair_bit   <= 1'b0;
        end else if (clear) begin
            pair_phase <= PH_FIRST;
            pair_bit   <= 1'b0;
        end else if (bypass_vn) begin
            pair_phase <= PH_FIRST;
        end else if (strobe) begin
            if (pair_phase == PH_FIRST) begin
                pair_bit   <= rng_bit;
                pair_phase <= PH_SECOND;
            end else begin
                pair_phase <= PH_FIRST;
            end
        end
    end

endmodule

// File: rtl/trng_bit_collector.sv
// Purpose: capture strobed TRNG bits, optionally debias, pack into words with overrun detect.
// Latency: word_valid rises one cycle after the strobe that completes a word.
// Backpressure: never stalls collection; a word completed while the output is held is dropped and overrun is set.
module trng_bit_collector
    import trng_bit_collector_pkg::*;
#(
    parameter int WORD_W = TRNG_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              rng_clk,
    input  logic              rst_n,
    input  logic              rst_trng_logic,
    input  logic              sample_strobe,
    input  logic              rng_bit,
    input  logic              bypass_vn,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              overrun
);

    logic              accept;
    logic              accept_bit;
    logic              complete;
    logic              out_free;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] next_word;

    trng_vn_debias u_debias (
        .rng_clk    (rng_clk),
        .rst_n      (rst_n),
        .strobe     (sample_strobe),
        .rng_bit    (rng_bit),
        .bypass_vn  (bypass_vn),
        .clear      (rst_trng_logic),
        .accept     (accept),
        .accept_bit (accept_bit)
    );

    // Word assembly: first accepted bit ends up at the MSB.
    assign next_word = {shreg[WORD_W-2:0], accept_bit};
    assign complete  = accept & (bit_cnt == CNT_W'(WORD_W - 1));
    // The holding register can take a new word if empty or being drained this cycle.
    assign out_free  = ~word_valid | word_ready;

    // Shift register and bit counter; counter wraps on word completion.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (rst_trng_logic) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= next_word;
            bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Output holding register and sticky overrun flag.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            overrun    <= 1'b0;
        end else if (rst_trng_logic) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (out_free) begin
                word_valid <= 1'b1;
                word_data  <= next_word;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule
